// File: rtl/axi_perf_sequencer.sv
// axi_perf_sequencer: issues programmed write/read burst sequences to an
// AXI traffic engine and counts the cycles spent in each phase.
module axi_perf_sequencer #(
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int NB_W      = 16,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] addr_stride,
    input  logic [7:0]        burst_len,
    input  logic [NB_W-1:0]   n_bursts,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    input  logic              cmpl,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  wr_cycles,
    output logic [CNT_W-1:0]  rd_cycles,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int OW = 4;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_DRAIN,
        S_RD_ISSUE,
        S_RD_DRAIN,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic              wtr_q, wtr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [7:0]        len_q, len_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [NB_W-1:0]   issued_q, issued_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              aborted_q, aborted_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [CNT_W-1:0]  wr_cyc_q, wr_cyc_d;
    logic [CNT_W-1:0]  rd_cyc_q, rd_cyc_d;
    logic              err_to_q, err_to_d;
    logic              err_sp_q, err_sp_d;

    logic              hs;
    logic              cmpl_ok;
    logic              spur;
    logic              run_st;
    logic              in_wr;
    logic              in_rd;
    logic              to_hit;
    logic [NB_W-1:0]   issued_nx;

    assign in_wr     = (state_q == S_WR_ISSUE) || (state_q == S_WR_DRAIN);
    assign in_rd     = (state_q == S_RD_ISSUE) || (state_q == S_RD_DRAIN);
    assign run_st    = in_wr || in_rd;
    assign hs        = req_valid && req_ready;
    assign cmpl_ok   = cmpl && (outst_q != '0);
    assign spur      = cmpl && (outst_q == '0);
    assign issued_nx = issued_q + NB_W'(hs);
    assign to_hit    = run_st && (outst_q != '0) && !cmpl && !hs
                       && (idle_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a phase with zero bursts ends the run at once
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (mode == 2'b01) ? S_RD_ISSUE : S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (nb_q == '0) begin
                    state_d = S_FIN;
                end else if (issued_nx == nb_q || abort) begin
                    state_d = S_WR_DRAIN;
                end
            end
            S_WR_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = (wtr_q && !aborted_q && !abort)
                              ? S_RD_ISSUE : S_FIN;
                end
            end
            S_RD_ISSUE: begin
                if (nb_q == '0) begin
                    state_d = S_FIN;
                end else if (issued_nx == nb_q || abort) begin
                    state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (to_hit) begin
            state_d = S_FIN;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        req_valid = 1'b0;
        req_write = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_WR_ISSUE: begin
                busy      = 1'b1;
                req_write = 1'b1;
                req_valid = (issued_q < nb_q)
                            && (outst_q < OW'(MAX_OUTST));
            end
            S_WR_DRAIN: begin
                busy      = 1'b1;
                req_write = 1'b1;
            end
            S_RD_ISSUE: begin
                busy      = 1'b1;
                req_valid = (issued_q < nb_q)
                            && (outst_q < OW'(MAX_OUTST));
            end
            S_RD_DRAIN: busy = 1'b1;
            S_FIN:      done = 1'b1;
            default:    ;
        endcase
    end

    // Datapath next-state: config latch, issue/outstanding tracking, counters
    always_comb begin
        wtr_d     = wtr_q;
        base_d    = base_q;
        stride_d  = stride_q;
        len_d     = len_q;
        nb_d      = nb_q;
        issued_d  = issued_q;
        outst_d   = outst_q;
        addr_d    = addr_q;
        aborted_d = aborted_q;
        idle_d    = idle_q;
        wr_cyc_d  = wr_cyc_q;
        rd_cyc_d  = rd_cyc_q;
        err_to_d  = err_to_q;
        err_sp_d  = err_sp_q;
        if (state_q == S_IDLE && start) begin
            wtr_d     = mode[1];
            base_d    = base_addr;
            stride_d  = addr_stride;
            len_d     = burst_len;
            nb_d      = n_bursts;
            issued_d  = '0;
            outst_d   = '0;
            addr_d    = base_addr;
            aborted_d = 1'b0;
            idle_d    = '0;
            wr_cyc_d  = '0;
            rd_cyc_d  = '0;
            err_to_d  = 1'b0;
            err_sp_d  = 1'b0;
        end else begin
            if (hs) begin
                issued_d = issued_nx;
                addr_d   = addr_q + stride_q;
            end
            if (state_q == S_WR_DRAIN && state_d == S_RD_ISSUE) begin
                issued_d = '0;
                addr_d   = base_q;
            end
            if (abort && run_st) begin
                aborted_d = 1'b1;
            end
            outst_d = outst_q + OW'(hs) - OW'(cmpl_ok);
            if (hs || cmpl) begin
                idle_d = '0;
            end else if (outst_q != '0) begin
                idle_d = idle_q + TW'(1);
            end else begin
                idle_d = '0;
            end
            if (in_wr && nb_q != '0 && wr_cyc_q != '1) begin
                wr_cyc_d = wr_cyc_q + CNT_W'(1);
            end
            if (in_rd && nb_q != '0 && rd_cyc_q != '1) begin
                rd_cyc_d = rd_cyc_q + CNT_W'(1);
            end
            if (spur) begin
                err_sp_d = 1'b1;
            end
            if (to_hit) begin
                err_to_d = 1'b1;
                outst_d  = '0;
                idle_d   = '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wtr_q     <= 1'b0;
            base_q    <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            nb_q      <= '0;
            issued_q  <= '0;
            outst_q   <= '0;
            addr_q    <= '0;
            aborted_q <= 1'b0;
            idle_q    <= '0;
            wr_cyc_q  <= '0;
            rd_cyc_q  <= '0;
            err_to_q  <= 1'b0;
            err_sp_q  <= 1'b0;
        end else begin
            wtr_q     <= wtr_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            len_q     <= len_d;
            nb_q      <= nb_d;
            issued_q  <= issued_d;
            outst_q   <= outst_d;
            addr_q    <= addr_d;
            aborted_q <= aborted_d;
            idle_q    <= idle_d;
            wr_cyc_q  <= wr_cyc_d;
            rd_cyc_q  <= rd_cyc_d;
            err_to_q  <= err_to_d;
            err_sp_q  <= err_sp_d;
        end
    end

    assign req_addr     = addr_q;
    assign req_len      = len_q;
    assign wr_cycles    = wr_cyc_q;
    assign rd_cycles    = rd_cyc_q;
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_axi_perf_sequencer.sv
// tb_axi_perf_sequencer: directed run scenarios for axi_perf_sequencer with
// an expected-request queue checked on every command handshake.
module tb_axi_perf_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] base_addr = '0;
    logic [31:0] addr_stride = '0;
    logic [7:0]  burst_len = '0;
    logic [15:0] n_bursts = '0;
    logic        req_ready = 1'b0;
    logic        cmpl = 1'b0;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        busy;
    logic        done;
    logic [31:0] wr_cycles;
    logic [31:0] rd_cycles;
    logic        err_timeout;
    logic        err_spurious;

    always #5 clk = ~clk;

    axi_perf_sequencer #(
        .CNT_W(32), .ADDR_W(32), .NB_W(16),
        .MAX_OUTST(4), .TIMEOUT(16)
    ) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .mode(mode), .base_addr(base_addr), .addr_stride(addr_stride),
        .burst_len(burst_len), .n_bursts(n_bursts),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .cmpl(cmpl), .busy(busy), .done(done),
        .wr_cycles(wr_cycles), .rd_cycles(rd_cycles),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [32:0] sb[$];
    int          hs_cnt;
    int          busy_n;
    int          wr_n;
    int          rd_n;
    bit          done_seen;
    bit          auto_c = 1'b0;
    logic [2:0]  pipe = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the negedge, let the posedge sample the inputs
    task automatic cyc();
        logic        hs;
        logic [32:0] e;
        hs = req_valid & req_ready;
        if (busy) begin
            busy_n++;
            if (req_write) wr_n++;
            else rd_n++;
        end
        if (done) done_seen = 1'b1;
        if (hs) begin
            hs_cnt++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("req_write", 64'(req_write), 64'(e[32]));
                chk("req_addr", 64'(req_addr), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        pipe  = {pipe[1:0], hs & auto_c};
        start = 1'b0;
        abort = 1'b0;
        cmpl  = auto_c ? pipe[2] : 1'b0;
    endtask

    task automatic clr_meas();
        hs_cnt    = 0;
        busy_n    = 0;
        wr_n      = 0;
        rd_n      = 0;
        done_seen = 1'b0;
    endtask

    task automatic go(input logic [1:0] m, input logic [31:0] b,
                      input logic [31:0] s, input logic [15:0] n);
        mode        = m;
        base_addr   = b;
        addr_stride = s;
        n_bursts    = n;
        start       = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_seen && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 64'(done_seen), 64'd1);
    endtask

    task automatic pulse_cmpl(input int n);
        for (int i = 0; i < n; i++) begin
            cmpl = 1'b1;
            cyc();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'd0);
        chk("rst_wr_cycles", 64'(wr_cycles), 64'd0);
        chk("rst_errs", 64'({err_timeout, err_spurious}), 64'd0);
        resetn = 1'b1;

        // write-only, 8 bursts, engine completes 3 cycles after accept
        clr_meas();
        burst_len = 8'h0f;
        req_ready = 1'b1;
        auto_c    = 1'b1;
        for (int i = 0; i < 8; i++)
            sb.push_back({1'b1, 32'h1000 + 32'(i) * 32'h100});
        go(2'b00, 32'h1000, 32'h100, 16'd8);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_req_len", 64'(req_len), 64'h0f);
        wait_done("t1_done", 200);
        chk("t1_issues", 64'(hs_cnt), 64'd8);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk("t1_wr_cycles", 64'(wr_cycles), 64'd12);
        chk("t1_wr_meas", 64'(wr_cycles), 64'(wr_n));
        chk("t1_rd_cycles", 64'(rd_cycles), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // completion while idle is spurious
        auto_c = 1'b0;
        pulse_cmpl(1);
        chk("sp_set", 64'(err_spurious), 64'd1);
        chk("sp_hold_wr", 64'(wr_cycles), 64'd12);

        // single burst that never completes -> timeout
        clr_meas();
        sb.push_back({1'b1, 32'h4000});
        go(2'b00, 32'h4000, 32'h40, 16'd1);
        chk("sp_cleared", 64'(err_spurious), 64'd0);
        cyc();
        chk("to_issued", 64'(hs_cnt), 64'd1);
        repeat (15) cyc();
        chk("to_not_yet", 64'(err_timeout), 64'd0);
        cyc();
        chk("to_set", 64'(err_timeout), 64'd1);
        chk("to_done", 64'(done), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        cyc();
        chk("to_done_pulse", 64'(done), 64'd0);
        chk("to_sticky", 64'(err_timeout), 64'd1);

        // write then read, completions withheld
        clr_meas();
        for (int i = 0; i < 4; i++)
            sb.push_back({1'b1, 32'h2000 + 32'(i) * 32'h10});
        go(2'b10, 32'h2000, 32'h10, 16'd4);
        chk("to_cleared", 64'(err_timeout), 64'd0);
        repeat (6) cyc();
        chk("wr_issues", 64'(hs_cnt), 64'd4);
        chk("wr_valid_low", 64'(req_valid), 64'd0);
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_write", 64'(req_write), 64'd1);
        req_ready = 1'b0;
        pulse_cmpl(4);
        for (int i = 0; i < 4; i++)
            sb.push_back({1'b0, 32'h2000 + 32'(i) * 32'h10});
        for (int k = 0; k < 10 && !req_valid; k++) cyc();
        chk("rd_valid", 64'(req_valid), 64'd1);
        chk("rd_write", 64'(req_write), 64'd0);
        chk("rd_base", 64'(req_addr), 64'h2000);
        req_ready = 1'b1;
        repeat (6) cyc();
        chk("rd_issues", 64'(hs_cnt), 64'd8);
        pulse_cmpl(4);
        wait_done("wr_rd_done", 20);
        chk("wr_rd_sb", 64'(sb.size()), 64'd0);
        chk("wr_rd_wcyc", 64'(wr_cycles), 64'(wr_n));
        chk("wr_rd_rcyc", 64'(rd_cycles), 64'(rd_n));

        // backpressure on a read-only run
        clr_meas();
        req_ready = 1'b0;
        auto_c    = 1'b1;
        sb.push_back({1'b0, 32'h3000});
        sb.push_back({1'b0, 32'h3020});
        go(2'b01, 32'h3000, 32'h20, 16'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(req_valid), 64'd1);
            chk("bp_addr", 64'(req_addr), 64'h3000);
            cyc();
        end
        chk("bp_no_issue", 64'(hs_cnt), 64'd0);
        req_ready = 1'b1;
        cyc();
        chk("bp_one_issue", 64'(hs_cnt), 64'd1);
        chk("bp_addr_step", 64'(req_addr), 64'h3020);
        wait_done("bp_done", 100);
        chk("bp_sb", 64'(sb.size()), 64'd0);

        // accept and completion in the same cycle at outstanding=2
        clr_meas();
        auto_c = 1'b0;
        for (int i = 0; i < 8; i++)
            sb.push_back({1'b1, 32'h5000 + 32'(i) * 32'h4});
        go(2'b00, 32'h5000, 32'h4, 16'd8);
        cyc();
        cyc();
        cmpl = 1'b1;
        cyc();
        repeat (4) cyc();
        chk("sc_issues", 64'(hs_cnt), 64'd5);
        chk("sc_stalled", 64'(req_valid), 64'd0);
        req_ready = 1'b0;
        pulse_cmpl(4);
        auto_c    = 1'b1;
        req_ready = 1'b1;
        wait_done("sc_done", 100);
        chk("sc_total", 64'(hs_cnt), 64'd8);
        chk("sc_sb", 64'(sb.size()), 64'd0);
        chk("sc_no_spur", 64'(err_spurious), 64'd0);

        // abort after 2 write issues in a write-then-read run
        clr_meas();
        auto_c = 1'b0;
        sb.push_back({1'b1, 32'h6000});
        sb.push_back({1'b1, 32'h6080});
        go(2'b10, 32'h6000, 32'h80, 16'd10);
        cyc();
        abort = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("ab_issues", 64'(hs_cnt), 64'd2);
        chk("ab_valid_low", 64'(req_valid), 64'd0);
        chk("ab_busy", 64'(busy), 64'd1);
        pulse_cmpl(2);
        wait_done("ab_done", 20);
        chk("ab_no_read", 64'(hs_cnt), 64'd2);
        chk("ab_rd_cycles", 64'(rd_cycles), 64'd0);
        chk("ab_sb", 64'(sb.size()), 64'd0);
        chk("ab_wr_meas", 64'(wr_cycles), 64'(wr_n));

        // zero bursts: done two cycles after start
        clr_meas();
        go(2'b10, 32'h7000, 32'h10, 16'd0);
        chk("z_done_early", 64'(done), 64'd0);
        chk("z_busy", 64'(busy), 64'd1);
        cyc();
        chk("z_done", 64'(done), 64'd1);
        chk("z_wr_cycles", 64'(wr_cycles), 64'd0);
        chk("z_rd_cycles", 64'(rd_cycles), 64'd0);
        cyc();
        chk("z_done_pulse", 64'(done), 64'd0);
        chk("z_no_issue", 64'(hs_cnt), 64'd0);

        // reset in the middle of a run
        clr_meas();
        req_ready = 1'b0;
        go(2'b00, 32'h8000, 32'h10, 16'd5);
        cyc();
        resetn = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_valid", 64'(req_valid), 64'd0);
        chk("mr_wr_cycles", 64'(wr_cycles), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        cyc();
        chk("mr_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
